sp_dma: RTL and testbench
=========================

// Module: sp_dma
// PURPOSE
//  Block-copy DMA engine for the SP core. Sits next to CTL on the single SRAM port:
//  CTL issues {src,dst,len}; sp_dma moves len 32-bit words from src to dst in
//  ascending order, using only cycles in which CTL grants it the SRAM port.
//  Lets the core keep executing while memory is copied in the background.
// PARAMETERS
//  ADDR_W  16  SRAM word-address width (matches sram_ADDR)
//  DATA_W  32  SRAM data width (matches sram_DI/sram_DO)
//  LEN_W   16  transfer-length counter width, in words
// PORTS
//  clk            in   1       single clock, all state on posedge
//  reset          in   1       asynchronous, active-high; aborts any transfer
//  cmd_valid      in   1       CTL presents a copy command this cycle
//  cmd_ready      out  1       engine idle, command accepted if cmd_valid
//  cmd_src        in   ADDR_W  first source word address
//  cmd_dst        in   ADDR_W  first destination word address
//  cmd_len        in   LEN_W   word count; 0 is legal
//  mem_grant      in   1       CTL is not using the SRAM this cycle
//  mem_req        out  1       engine wants the SRAM port this cycle
//  sram_ADDR      out  ADDR_W  SRAM address (valid when sram_EN)
//  sram_DI        out  DATA_W  SRAM write data
//  sram_EN        out  1       SRAM enable, only ever high when mem_grant high
//  sram_WE        out  1       SRAM write enable
//  sram_DO        in   DATA_W  SRAM read data, valid the cycle after a read
//  busy           out  1       transfer in progress (state != IDLE)
//  done           out  1       one-cycle pulse on completion
//  remaining      out  LEN_W   words still to copy
// BEHAVIOUR
//  Reset: state IDLE; busy, done, mem_req, sram_EN, sram_WE = 0; sram_ADDR,
//   sram_DI, remaining, internal src/dst/buffer regs = 0; cmd_ready = 1.
//  Accept: cmd_valid & cmd_ready at posedge latches src, dst, len; next state READ
//   (len!=0) or DONE (len==0, no memory access). cmd_ready = (state==IDLE).
//  FSM: IDLE -> READ -> CAPT -> WRITE -> (READ if remaining>1 else DONE) -> IDLE.
//   READ : mem_req=1; if mem_grant: EN=1 WE=0 ADDR=src, go CAPT; else stall.
//   CAPT : no SRAM access; buffer <= sram_DO unconditionally (grant ignored).
//   WRITE: mem_req=1; if mem_grant: EN=1 WE=1 ADDR=dst DI=buffer, src++, dst++,
//          remaining--, then next state; else stall holding buffer.
//   DONE : done=1 for exactly one cycle, busy=1, then IDLE.
//  sram_EN/WE/ADDR/DI are combinational from state, regs and mem_grant; zero
//   when not driving. EN is never high without mem_grant.
//  Latency with mem_grant held 1: 3 cycles/word; done high in cycle 3*len+1
//   after the accept edge; cmd_ready returns the cycle after done.
//  Width rules: src/dst increment modulo 2^ADDR_W (wrap 0xFFFF -> 0x0000);
//   remaining counts down, never underflows.
//  Overlap: strict ascending word copy; dst>src overlap replicates data (by design).
//  cmd_valid while busy: ignored, no state change.
//  Reset mid-transfer: immediate abort to reset values; no done pulse; words
//   already written stay written.
// STRUCTURE
//  sp_pkg (shared): ADDR_W/DATA_W/LEN_W defaults, dma_state_t enum
//   {IDLE,READ,CAPT,WRITE,DONE}, also used by CTL for grant decode.
//  Single module, no sub-module: one FSM, two address regs, down counter,
//   data buffer, combinational SRAM drive.
// TESTING
//  1 len=4 src=0x10 dst=0x80, grant=1 -> mem[0x80..0x83]=mem[0x10..0x13], done at
//    cycle 13 after accept, exactly 4 writes, remaining=0.
//  2 len=0 -> no sram_EN ever, done at cycle 1, busy low cycle 2.
//  3 len=2, grant toggled 1,0,1,0 -> EN only when grant=1; data correct; CAPT
//    captures even with grant=0; completes after extra stall cycles.
//  4 src=0xFFFE dst=0x0100 len=3 -> reads 0xFFFE,0xFFFF,0x0000; writes 0x100..0x102.
//  5 cmd_valid with new cmd while busy -> ignored; original copy completes unchanged.
//  6 reset asserted during WRITE of word 2 of 5 -> all outputs 0 same cycle, no done,
//    words 0-1 at dst, dst+2.. untouched; new cmd afterwards runs normally.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared SP-core definitions: default bus widths and the DMA state encoding.
// CTL also imports this package to decode which DMA phases need the SRAM.
package sp_pkg;

   localparam int SP_ADDR_W = 16;
   localparam int SP_DATA_W = 32;
   localparam int SP_LEN_W  = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      CAPT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } dma_state_t;

endpackage

// File: rtl/sp_dma.sv
// Background block-copy engine on the shared SRAM port.
// Copies len words from src to dst in ascending order, one word per
// read/capture/write round, using the port only in cycles CTL grants it.
module sp_dma
   import sp_pkg::*;
#(
   parameter int ADDR_W = SP_ADDR_W,
   parameter int DATA_W = SP_DATA_W,
   parameter int LEN_W  = SP_LEN_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              mem_grant,
   output logic              mem_req,
   output logic [ADDR_W-1:0] sram_ADDR,
   output logic [DATA_W-1:0] sram_DI,
   output logic              sram_EN,
   output logic              sram_WE,
   input  logic [DATA_W-1:0] sram_DO,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  remaining
);

   dma_state_t        state_reg;
   logic [ADDR_W-1:0] src_reg;
   logic [ADDR_W-1:0] dst_reg;
   logic [LEN_W-1:0]  rem_reg;
   logic [DATA_W-1:0] buf_reg;

   logic rd_go;
   logic wr_go;

   // A memory phase only advances in a cycle where CTL leaves the port free.
   assign rd_go = (state_reg == READ)  && mem_grant;
   assign wr_go = (state_reg == WRITE) && mem_grant;

   // Copy sequencer: address/count registers advance only on a granted write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         src_reg   <= '0;
         dst_reg   <= '0;
         rem_reg   <= '0;
         buf_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cmd_valid) begin
                  src_reg   <= cmd_src;
                  dst_reg   <= cmd_dst;
                  rem_reg   <= cmd_len;
                  state_reg <= (cmd_len != '0) ? READ : DONE;
               end
            end
            READ: begin
               if (mem_grant) begin
                  state_reg <= CAPT;
               end
            end
            CAPT: begin
               // Read data is on sram_DO now regardless of who owns the port.
               buf_reg   <= sram_DO;
               state_reg <= WRITE;
            end
            WRITE: begin
               if (mem_grant) begin
                  src_reg   <= src_reg + ADDR_W'(1);
                  dst_reg   <= dst_reg + ADDR_W'(1);
                  rem_reg   <= (rem_reg != '0) ? rem_reg - LEN_W'(1) : '0;
                  state_reg <= (rem_reg > LEN_W'(1)) ? READ : DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // SRAM drive is gated by the grant so EN can never assert on a cycle CTL owns.
   always_comb begin
      sram_EN   = rd_go || wr_go;
      sram_WE   = wr_go;
      sram_ADDR = '0;
      sram_DI   = '0;
      if (rd_go) begin
         sram_ADDR = src_reg;
      end else if (wr_go) begin
         sram_ADDR = dst_reg;
         sram_DI   = buf_reg;
      end
   end

   assign mem_req   = (state_reg == READ) || (state_reg == WRITE);
   assign cmd_ready = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);
   assign remaining = rem_reg;

endmodule

// File: tb/tb_sp_dma.sv
// Bench for sp_dma: a transaction-level copy model (sequence of granted read,
// dead cycle, granted write per word, then a completion cycle) plus a
// word-array reference memory, checked against the DUT every cycle.
module tb_sp_dma;

   localparam int OP_R = 0;
   localparam int OP_G = 1;
   localparam int OP_W = 2;
   localparam int OP_D = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_src = '0;
   logic [15:0] cmd_dst = '0;
   logic [15:0] cmd_len = '0;
   logic        mem_grant = 1'b1;
   logic        mem_req;
   logic [15:0] sram_ADDR;
   logic [31:0] sram_DI;
   logic        sram_EN;
   logic        sram_WE;
   logic [31:0] sram_DO;
   logic        busy;
   logic        done;
   logic [15:0] remaining;

   sp_dma dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .cmd_len   (cmd_len),
      .mem_grant (mem_grant),
      .mem_req   (mem_req),
      .sram_ADDR (sram_ADDR),
      .sram_DI   (sram_DI),
      .sram_EN   (sram_EN),
      .sram_WE   (sram_WE),
      .sram_DO   (sram_DO),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int gmode  = 0;

   // model state
   int          ops[$];
   bit          m_active = 1'b0;
   logic [15:0] m_src, m_dst, m_rem;
   int          m_k;
   logic [31:0] m_rd_val;
   int          acc_cyc = 0;
   int          lat = -1;
   int          done_cnt = 0;
   int          wr_seen = 0;
   int          en_seen = 0;
   bit          ref_init = 1'b0;
   bit          mem_init = 1'b0;

   logic [31:0] tb_mem  [0:65535];
   logic [31:0] ref_mem [0:65535];
   logic [31:0] do_reg = '0;

   assign sram_DO = do_reg;

   function automatic logic [31:0] fval(input logic [15:0] a);
      return ({16'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM: registered read, write on enable; preloaded with an address hash
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 65536; i++) tb_mem[i] <= fval(16'(i));
         mem_init <= 1'b1;
      end else if (sram_EN) begin
         if (sram_WE) tb_mem[sram_ADDR] <= sram_DI;
         else         do_reg <= tb_mem[sram_ADDR];
      end
   end

   // per-cycle compare against the transaction model
   always @(negedge clk) begin
      logic [15:0] a;
      if (!ref_init) begin
         for (int i = 0; i < 65536; i++) ref_mem[i] = fval(16'(i));
         ref_init = 1'b1;
      end
      if (sram_EN && sram_WE) wr_seen++;
      if (sram_EN) en_seen++;
      if (reset) begin
         chk("rst_busy", {31'd0, busy}, 0);
         chk("rst_done", {31'd0, done}, 0);
         chk("rst_req",  {31'd0, mem_req}, 0);
         chk("rst_en",   {31'd0, sram_EN}, 0);
         chk("rst_we",   {31'd0, sram_WE}, 0);
         chk("rst_addr", {16'd0, sram_ADDR}, 0);
         chk("rst_di",   sram_DI, 0);
         chk("rst_rem",  {16'd0, remaining}, 0);
         chk("rst_rdy",  {31'd0, cmd_ready}, 1);
         ops.delete();
         m_active = 1'b0;
         m_rem = '0;
      end else if (!m_active) begin
         chk("idle_busy", {31'd0, busy}, 0);
         chk("idle_done", {31'd0, done}, 0);
         chk("idle_req",  {31'd0, mem_req}, 0);
         chk("idle_en",   {31'd0, sram_EN}, 0);
         chk("idle_rdy",  {31'd0, cmd_ready}, 1);
         chk("idle_rem",  {16'd0, remaining}, {16'd0, m_rem});
         if (cmd_valid) begin
            m_src = cmd_src;
            m_dst = cmd_dst;
            m_rem = cmd_len;
            m_k = 0;
            for (int i = 0; i < int'(cmd_len); i++) begin
               ops.push_back(OP_R);
               ops.push_back(OP_G);
               ops.push_back(OP_W);
            end
            ops.push_back(OP_D);
            m_active = 1'b1;
            acc_cyc = cyc;
         end
      end else begin
         chk("act_busy", {31'd0, busy}, 1);
         chk("act_rdy",  {31'd0, cmd_ready}, 0);
         chk("act_rem",  {16'd0, remaining}, {16'd0, m_rem});
         case (ops[0])
            OP_R: begin
               a = m_src + 16'(m_k);
               chk("rd_req",  {31'd0, mem_req}, 1);
               chk("rd_done", {31'd0, done}, 0);
               chk("rd_en",   {31'd0, sram_EN}, {31'd0, mem_grant});
               chk("rd_we",   {31'd0, sram_WE}, 0);
               chk("rd_addr", {16'd0, sram_ADDR}, mem_grant ? {16'd0, a} : 32'd0);
               chk("rd_di",   sram_DI, 0);
               if (mem_grant) begin
                  m_rd_val = ref_mem[a];
                  void'(ops.pop_front());
               end
            end
            OP_G: begin
               chk("cap_req",  {31'd0, mem_req}, 0);
               chk("cap_en",   {31'd0, sram_EN}, 0);
               chk("cap_done", {31'd0, done}, 0);
               chk("cap_addr", {16'd0, sram_ADDR}, 0);
               void'(ops.pop_front());
            end
            OP_W: begin
               a = m_dst + 16'(m_k);
               chk("wr_req",  {31'd0, mem_req}, 1);
               chk("wr_done", {31'd0, done}, 0);
               chk("wr_en",   {31'd0, sram_EN}, {31'd0, mem_grant});
               chk("wr_we",   {31'd0, sram_WE}, {31'd0, mem_grant});
               chk("wr_addr", {16'd0, sram_ADDR}, mem_grant ? {16'd0, a} : 32'd0);
               chk("wr_di",   sram_DI, mem_grant ? m_rd_val : 32'd0);
               if (mem_grant) begin
                  ref_mem[a] = m_rd_val;
                  m_k++;
                  m_rem = m_rem - 16'd1;
                  void'(ops.pop_front());
               end
            end
            default: begin
               chk("dn_done", {31'd0, done}, 1);
               chk("dn_req",  {31'd0, mem_req}, 0);
               chk("dn_en",   {31'd0, sram_EN}, 0);
               void'(ops.pop_front());
               m_active = 1'b0;
               lat = cyc - acc_cyc;
               done_cnt++;
               $display("copy done src=%h dst=%h words=%0d latency=%0d", m_src, m_dst, m_k, lat);
            end
         endcase
      end
   end

   // grant pattern generator
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (gmode)
            0:       mem_grant = 1'b1;
            1:       mem_grant = ~mem_grant;
            default: mem_grant = ($urandom % 4) != 0;
         endcase
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (m_active && t < 2000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (m_active) chk("idle_timeout", 1, 0);
   endtask

   task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
      wait_idle();
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_src = s;
      cmd_dst = d;
      cmd_len = l;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, e0, d0, bad;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // 1: basic 4-word copy, full grant
      gmode = 0;
      w0 = wr_seen;
      issue(16'h0010, 16'h0080, 16'd4);
      wait_idle();
      chk("t1_latency", lat, 13);
      chk("t1_writes", wr_seen - w0, 4);
      chk("t1_remaining", {16'd0, remaining}, 0);
      for (int i = 0; i < 4; i++)
         chk("t1_data", tb_mem[16'h0080 + 16'(i)], fval(16'h0010 + 16'(i)));

      // 2: zero length, no memory traffic
      e0 = en_seen;
      issue(16'h0200, 16'h0300, 16'd0);
      wait_idle();
      chk("t2_latency", lat, 1);
      chk("t2_no_en", en_seen - e0, 0);
      chk("t2_busy_low", {31'd0, busy}, 0);

      // 3: toggling grant
      gmode = 1;
      issue(16'h0020, 16'h0040, 16'd2);
      wait_idle();
      chk("t3_stalled", {31'd0, (lat > 7)}, 1);
      chk("t3_data0", tb_mem[16'h0040], fval(16'h0020));
      chk("t3_data1", tb_mem[16'h0041], fval(16'h0021));

      // 4: source address wrap
      gmode = 0;
      issue(16'hFFFE, 16'h0100, 16'd3);
      wait_idle();
      chk("t4_data0", tb_mem[16'h0100], fval(16'hFFFE));
      chk("t4_data1", tb_mem[16'h0101], fval(16'hFFFF));
      chk("t4_data2", tb_mem[16'h0102], fval(16'h0000));

      // 5: command while busy is ignored
      issue(16'h0400, 16'h0500, 16'd5);
      repeat (3) @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_src = 16'h0600;
      cmd_dst = 16'h0700;
      cmd_len = 16'd2;
      repeat (2) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_idle();
      chk("t5_latency", lat, 16);
      chk("t5_tail", tb_mem[16'h0504], fval(16'h0404));
      chk("t5_untouched", tb_mem[16'h0700], fval(16'h0700));

      // 6: reset during the write of word 2 of 5
      d0 = done_cnt;
      issue(16'h0800, 16'h0900, 16'd5);
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_no_done", done_cnt - d0, 0);
      chk("t6_word1", tb_mem[16'h0901], fval(16'h0801));
      chk("t6_word2_untouched", tb_mem[16'h0902], fval(16'h0902));
      issue(16'h0A00, 16'h0B00, 16'd3);
      wait_idle();
      chk("t6_after_latency", lat, 10);
      chk("t6_after_data", tb_mem[16'h0B02], fval(16'h0A02));

      // random commands, random grant, overlapping windows allowed
      gmode = 2;
      for (int n = 0; n < 25; n++) begin
         issue(16'h1000 + 16'($urandom_range(0, 63)),
               16'h1000 + 16'($urandom_range(0, 63)),
               16'($urandom_range(0, 12)));
      end
      wait_idle();
      repeat (2) @(posedge clk);
      #1;

      bad = 0;
      for (int i = 0; i < 65536; i++)
         if (tb_mem[i] !== ref_mem[i]) bad++;
      chk("final_mem_mismatches", bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
